bitrev_stream_checker: RTL and testbench

Consumes a stream of (original, transformed) word pairs over a valid/ready handshake and checks each transformed word against the bit-reversal of its original. It is the receiving, checking end of the bit-reversal stimulus path: the stimulus generator drives random words and their reversals, and this block accepts them, counts matches and mismatches, and captures the first failure. A run is a fixed number of samples, after which the block reports done and pass/fail. It sits between the stimulus generator and the simulation-termination logic.

---
 rtl/bitrev_stream_checker.sv | 157 +++++++++++++++
 tb/tb_bitrev_stream_checker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitrev_stream_checker.sv
// Checks a stream of (word, bit-reversed word) pairs over valid/ready and scores a run.
// Define BITREV_CHK_STALL_EN to throttle in_ready with a 16-bit LFSR during a run.
module bitrev_stream_checker #(
    parameter int WIDTH       = 8,
    parameter int NUM_SAMPLES = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_rev,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] fidx_q, fidx_d;
    logic [WIDTH-1:0] fdata_q, fdata_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             seen_q, seen_d;
    logic             pass_q, pass_d;
    logic             run_rdy;
    logic             xfer;
    logic             ok;

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef BITREV_CHK_STALL_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == S_RUN) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end else if (start) begin
            lfsr_d = LFSR_SEED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end

    assign run_rdy = lfsr_q[0];
`else
    assign run_rdy = 1'b1;
`endif

    assign in_ready = (state_q == S_RUN) && run_rdy;
    assign xfer     = in_valid && in_ready;
    assign ok       = (in_rev == bitrev(in_data));

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fdata_d = fdata_q;
        idx_d   = idx_q;
        seen_d  = seen_q;
        pass_d  = pass_q;
        unique case (state_q)
            S_RUN: begin
                if (xfer) begin
                    if (ok) begin
                        match_d = sat_inc(match_q);
                    end else begin
                        err_d = sat_inc(err_q);
                        if (!seen_q) begin
                            seen_d  = 1'b1;
                            fidx_d  = idx_q;
                            fdata_d = in_data;
                        end
                    end
                    idx_d = sat_inc(idx_q);
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        pass_d  = (err_d == '0);
                    end
                end
            end
            default: begin
                // IDLE and DONE both launch a fresh run on start
                if (start) begin
                    state_d = S_RUN;
                    match_d = '0;
                    err_d   = '0;
                    fidx_d  = '0;
                    fdata_d = '0;
                    idx_d   = '0;
                    seen_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            match_q <= '0;
            err_q   <= '0;
            fidx_q  <= '0;
            fdata_q <= '0;
            idx_q   <= '0;
            seen_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fdata_q <= fdata_d;
            idx_q   <= idx_d;
            seen_q  <= seen_d;
            pass_q  <= pass_d;
        end
    end

    assign busy           = (state_q == S_RUN);
    assign done           = (state_q == S_DONE);
    assign pass           = pass_q;
    assign match_count    = match_q;
    assign err_count      = err_q;
    assign first_err_idx  = fidx_q;
    assign first_err_data = fdata_q;

endmodule

// File: tb/tb_bitrev_stream_checker.sv
// Randomized bench for bitrev_stream_checker against a queue-based run model.
module tb_bitrev_stream_checker;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [W-1:0]  in_rev = '0;
    logic          busy, done, pass;
    logic [CW-1:0] match_count, err_count, first_err_idx;
    logic [W-1:0]  first_err_data;

    int tests = 0;
    int fails = 0;
    int ready_low_seen = 0;

    bitrev_stream_checker #(.WIDTH(W), .NUM_SAMPLES(N), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_rev(in_rev),
        .busy(busy), .done(done), .pass(pass),
        .match_count(match_count), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_data(first_err_data)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a run is the list of accepted pairs; outputs are derived from it.
    typedef struct {
        logic [W-1:0] d;
        bit           ok;
    } rec_t;
    typedef enum int {M_IDLE, M_RUN, M_DONE} mst_t;

    rec_t        run_q[$];
    mst_t        mst = M_IDLE;
    logic [15:0] mlfsr = 16'hACE1;

    function automatic bit m_ready();
`ifdef BITREV_CHK_STALL_EN
        return (mst == M_RUN) && mlfsr[0];
`else
        return (mst == M_RUN);
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst = M_IDLE;
            run_q.delete();
            mlfsr = 16'hACE1;
        end else if (mst == M_RUN) begin
            if (in_valid && m_ready()) begin
                run_q.push_back('{d: in_data, ok: (in_rev == rev(in_data))});
                if (run_q.size() == N) mst = M_DONE;
            end
            mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
        end else if (start) begin
            mst = M_RUN;
            run_q.delete();
            mlfsr = 16'hACE1;
        end
    end

    always @(negedge clk) begin
        int m, e, fi;
        logic [W-1:0] fd;
        m = 0; e = 0; fi = -1; fd = '0;
        foreach (run_q[i]) begin
            if (run_q[i].ok) m++;
            else begin
                if (fi < 0) begin fi = i; fd = run_q[i].d; end
                e++;
            end
        end
        chk("in_ready", 32'(in_ready), 32'(m_ready()));
        chk("busy", 32'(busy), 32'(mst == M_RUN));
        chk("done", 32'(done), 32'(mst == M_DONE));
        chk("pass", 32'(pass), 32'((mst == M_DONE) && e == 0));
        chk("match_count", 32'(match_count), 32'(m));
        chk("err_count", 32'(err_count), 32'(e));
        chk("first_err_idx", 32'(first_err_idx), 32'((fi < 0) ? 0 : fi));
        chk("first_err_data", 32'(first_err_data), 32'(fd));
        if (mst == M_RUN && !in_ready) ready_low_seen++;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [W-1:0] d, input logic [W-1:0] r,
                        input bit st, input bit keep);
        bit rdy;
        int guard;
        in_valid = 1'b1;
        in_data  = d;
        in_rev   = r;
        start    = st;
        guard    = 0;
        forever begin
            rdy = in_ready;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (rdy) break;
            guard++;
            if (guard > 200) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_data = W'($urandom);
            in_rev  = W'($urandom);
            @(negedge clk);
        end
    endtask

    logic [W-1:0] clean_d [N];
    logic [W-1:0] dd, rr;

    initial begin
        clean_d[0] = 8'h01; clean_d[1] = 8'hA5; clean_d[2] = 8'h0F;
        clean_d[3] = 8'h3C; clean_d[4] = 8'h80; clean_d[5] = 8'h12;
        clean_d[6] = 8'hC3; clean_d[7] = 8'h7E;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_match", 32'(match_count), 32'd0);
        chk("model_rev_01", 32'(rev(8'h01)), 32'h80);
        chk("model_rev_0f", 32'(rev(8'h0F)), 32'hF0);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_ready", 32'(in_ready), 32'd0);

        // Clean run
        pulse_start();
        for (int i = 0; i < N; i++) send(clean_d[i], rev(clean_d[i]), 1'b0, i < N - 1);
`ifndef BITREV_CHK_STALL_EN
        chk("clean_done_latency", 32'(done), 32'd1);
`endif
        chk("clean_pass", 32'(pass), 32'd1);
        chk("clean_match", 32'(match_count), 32'd8);
        chk("clean_err", 32'(err_count), 32'd0);

        // Injected errors
        pulse_start();
        for (int i = 0; i < N; i++) begin
            dd = clean_d[i]; rr = rev(clean_d[i]);
            if (i == 2) begin dd = 8'h12; rr = 8'h00; end
            if (i == 5) begin dd = 8'h34; rr = 8'hFF; end
            send(dd, rr, 1'b0, i < N - 1);
        end
        chk("inj_pass", 32'(pass), 32'd0);
        chk("inj_err", 32'(err_count), 32'd2);
        chk("inj_match", 32'(match_count), 32'd6);
        chk("inj_fidx", 32'(first_err_idx), 32'd2);
        chk("inj_fdata", 32'(first_err_data), 32'h12);

        // Gaps, start during RUN, start on the final transfer
        pulse_start();
        for (int i = 0; i < N; i++) begin
            dd = W'($urandom);
            send(dd, rev(dd), (i == 3) || (i == N - 1), 1'b0);
            gap(i % 2);
        end
        repeat (2) @(negedge clk);
        chk("gap_total", 32'(match_count + err_count), 32'd8);
        chk("gap_done_hold", 32'(done), 32'd1);

        // Random runs, each restarted from DONE
        for (int r = 0; r < 20; r++) begin
            pulse_start();
            chk("restart_clear", 32'(match_count + err_count), 32'd0);
            for (int i = 0; i < N; i++) begin
                dd = W'($urandom);
                rr = rev(dd);
                if ($urandom_range(3) == 0) rr = rr ^ W'($urandom_range(1, 255));
                send(dd, rr, 1'b0, 1'b0);
                gap($urandom_range(0, 2));
            end
            chk("rand_done", 32'(done), 32'd1);
        end

        // Mid-run reset
        pulse_start();
        for (int i = 0; i < 4; i++) send(clean_d[i], rev(clean_d[i]), 1'b0, i < 3);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_match", 32'(match_count), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        for (int i = 0; i < N; i++) send(clean_d[i], rev(clean_d[i]), 1'b0, i < N - 1);
        chk("after_rst_match", 32'(match_count), 32'd8);
        chk("after_rst_pass", 32'(pass), 32'd1);
`ifdef BITREV_CHK_STALL_EN
        chk("stall_seen", 32'(ready_low_seen > 0), 32'd1);
`endif
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
